// File: rtl/mdu_sched_if.sv
// E-stage to MDU handshake: operation request and operands in, HI/LO and
// busy/stall status out.
interface mdu_sched_if;
  logic [2:0]  e_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_is_md;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output e_op, e_rs, e_rt, d_is_md,
    input  start, busy, stall_md, hi, lo
  );

  modport slave (
    input  e_op, e_rs, e_rt, d_is_md,
    output start, busy, stall_md, hi, lo
  );
endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide sequencer: owns HI/LO and models fixed mult/div latency
// with a down-counter.
module mdu_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_sched_if.slave  md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        div_zero_q, div_zero_d;

  logic        is_signed;
  logic        is_long_op;
  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] div_a, div_b, quot, rem;
  logic        div_unused;

  assign is_signed  = (md.e_op == OP_MULT) || (md.e_op == OP_DIV);
  assign is_long_op = (md.e_op >= OP_MULT) && (md.e_op <= OP_DIVU);

  // Low 64 bits of the sign/zero-extended product are the exact 64-bit result.
  always_comb begin
    mul_a = is_signed ? {{32{md.e_rs[31]}}, md.e_rs} : {32'd0, md.e_rs};
    mul_b = is_signed ? {{32{md.e_rt[31]}}, md.e_rt} : {32'd0, md.e_rt};
    prod  = mul_a * mul_b;
  end

  // 33-bit operands keep -2^31 / -1 well defined; a zero divisor is replaced
  // so the divider never sees it, the result is discarded anyway.
  always_comb begin
    div_a = is_signed ? {md.e_rs[31], md.e_rs} : {1'b0, md.e_rs};
    div_b = is_signed ? {md.e_rt[31], md.e_rt} : {1'b0, md.e_rt};
    if (md.e_rt == 32'd0) begin
      div_b = 33'd1;
    end
    quot = $signed(div_a) / $signed(div_b);
    rem  = $signed(div_a) % $signed(div_b);
  end

  assign div_unused = ^{quot[32], rem[32]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        case (md.e_op)
          OP_MULT, OP_MULTU: begin
            pend_hi_d  = prod[63:32];
            pend_lo_d  = prod[31:0];
            div_zero_d = 1'b0;
            cnt_d      = 4'(MULT_CYC);
            state_d    = S_RUN;
          end
          OP_DIV, OP_DIVU: begin
            pend_hi_d  = rem[31:0];
            pend_lo_d  = quot[31:0];
            div_zero_d = (md.e_rt == 32'd0);
            cnt_d      = 4'(DIV_CYC);
            state_d    = S_RUN;
          end
          OP_MTHI: hi_d = md.e_rs;
          OP_MTLO: lo_d = md.e_rs;
          default: ;
        endcase
      end
      S_RUN: begin
        // Requests arriving while running are ignored; only the count advances.
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
          if (!div_zero_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      pend_hi_q  <= 32'd0;
      pend_lo_q  <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign md.busy     = (state_q == S_RUN);
  assign md.start    = is_long_op && (state_q == S_IDLE);
  assign md.stall_md = md.d_is_md && (md.start || md.busy);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized and directed bench for mdu_sched against a cycle-count model of
// HI/LO and busy, with literal checks for the hand-worked cases.
module tb_mdu_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_sched_if bus ();

  mdu_sched #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: committed HI/LO, pending result, cycles of busy remaining.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  int          m_left = 0;
  bit          m_dz = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (sgn) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  always @(posedge clk) begin : model
    logic [63:0] res;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0; m_dz = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && !m_dz) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else begin
      case (bus.e_op)
        3'd1, 3'd2: begin
          res = ref_mult(bus.e_op == 3'd1, bus.e_rs, bus.e_rt);
          {m_phi, m_plo} = res;
          m_dz = 1'b0;
          m_left = MC;
        end
        3'd3, 3'd4: begin
          m_dz = (bus.e_rt == 32'd0);
          if (!m_dz) begin
            res = ref_div(bus.e_op == 3'd3, bus.e_rs, bus.e_rt);
            {m_phi, m_plo} = res;
          end
          m_left = DC;
        end
        3'd5: m_hi = bus.e_rs;
        3'd6: m_lo = bus.e_rs;
        default: ;
      endcase
      if (bus.e_op >= 3'd1 && bus.e_op <= 3'd6)
        $display("txn t=%0t op=%0d rs=%h rt=%h", $time, bus.e_op, bus.e_rs, bus.e_rt);
    end
  end

  always @(negedge clk) begin : compare
    logic e_busy, e_start, e_stall;
    if (chk_en) begin
      e_busy  = (m_left > 0);
      e_start = (bus.e_op >= 3'd1 && bus.e_op <= 3'd4) && !e_busy;
      e_stall = bus.d_is_md && (e_start || e_busy);
      check("busy",     {31'd0, bus.busy},     {31'd0, e_busy});
      check("start",    {31'd0, bus.start},    {31'd0, e_start});
      check("stall_md", {31'd0, bus.stall_md}, {31'd0, e_stall});
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  task automatic set_in(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt, input logic d);
    bus.e_op = op;
    bus.e_rs = rs;
    bus.e_rt = rt;
    bus.d_is_md = d;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    set_in(op, rs, rt, 1'b0);
    next_cyc();
    set_in(3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Counts busy cycles after an issue; HI/LO must hold old values meanwhile.
  task automatic wait_done(input string name, input int exp_n,
                           input logic [31:0] old_hi, input logic [31:0] old_lo,
                           input logic [31:0] new_hi, input logic [31:0] new_lo);
    int n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 40) begin
      check({name, "_hold_hi"}, bus.hi, old_hi);
      check({name, "_hold_lo"}, bus.lo, old_lo);
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, n, exp_n);
    check({name, "_hi"}, bus.hi, new_hi);
    check({name, "_lo"}, bus.lo, new_lo);
    next_cyc();
  endtask

  initial begin
    set_in(3'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    repeat (2) next_cyc();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    next_cyc();
    reset = 1'b0;
    next_cyc();

    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done("mult", MC, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done("multu", MC, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFE);
    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div", DC, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'd4, 32'd7, 32'd2);
    wait_done("divu", DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);

    issue(3'd5, 32'hAAAA_0000, 32'd0);
    issue(3'd6, 32'h0000_BBBB, 32'd0);
    @(negedge clk);
    check("mthi", bus.hi, 32'hAAAA_0000);
    check("mtlo", bus.lo, 32'h0000_BBBB);
    next_cyc();
    issue(3'd4, 32'd7, 32'd0);
    wait_done("divu0", DC, 32'hAAAA_0000, 32'h0000_BBBB, 32'hAAAA_0000, 32'h0000_BBBB);

    // mult in flight with a div offered on cycle 2 and D-stage MDU op waiting
    for (int c = 0; c <= 6; c++) begin
      set_in((c == 0) ? 3'd1 : (c == 2) ? 3'd3 : 3'd0,
             (c == 0) ? 32'd3 : 32'd100, (c == 0) ? 32'd5 : 32'd7, c < 6);
      @(negedge clk);
      check($sformatf("stall_c%0d", c), {31'd0, bus.stall_md}, {31'd0, c <= 5});
      next_cyc();
    end
    check("ovl_busy", {31'd0, bus.busy}, 32'd0);
    check("ovl_hi", bus.hi, 32'd0);
    check("ovl_lo", bus.lo, 32'd15);

    // reset in cycle 4 of a divide aborts it
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) next_cyc();
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    repeat (15) next_cyc();
    @(negedge clk);
    check("abort_late_hi", bus.hi, 32'd0);
    check("abort_late_lo", bus.lo, 32'd0);
    next_cyc();

    for (int i = 0; i < 800; i++) begin
      logic [31:0] rs, rt;
      case ($urandom_range(0, 3))
        0: rs = 32'h8000_0000;
        1: rs = 32'hFFFF_FFFF;
        default: rs = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rt = 32'd0;
        1: rt = 32'hFFFF_FFFF;
        2: rt = $urandom_range(1, 9);
        default: rt = $urandom;
      endcase
      set_in(3'($urandom_range(0, 7)), rs, rt, 1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 79) == 0);
      next_cyc();
    end
    reset = 1'b0;
    set_in(3'd0, 32'd0, 32'd0, 1'b0);
    repeat (DC + 2) next_cyc();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_sched.md
Name: mdu_sched

Overview:
Multiply/divide sequencing unit for the P6 pipelined MIPS core. Sits in the E stage and owns HI/LO. Accepts mult/multu/div/divu/mthi/mtlo from E and models fixed multi-cycle latency with a busy counter. Drives the D-stage stall request so that MDU-class instructions wait while an operation is in flight.

Parameters:
MULT_CYC, 5, cycles busy is held for mult/multu (1..15)
DIV_CYC, 10, cycles busy is held for div/divu (1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
e_op  input  3  E-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
e_rs  input  32  forwarded rs operand
e_rt  input  32  forwarded rt operand
d_is_md  input  1  D-stage instruction is any MDU-class op (mult/div/mfhi/mflo/mthi/mtlo family)
start  output  1  combinational: 1 when e_op is in 1..4 and busy==0
busy  output  1  registered: operation in flight
stall_md  output  1  combinational: d_is_md & (start | busy)
hi  output  32  HI register, readable by mfhi in E
lo  output  32  LO register, readable by mflo in E

Behaviour:
- Reset (synchronous): hi=0, lo=0, busy=0, counter=0, pending result regs=0. Reset mid-operation aborts it; hi/lo do NOT receive the pending result.
- Internal state: IDLE (busy=0) and RUN (busy=1); 4-bit down-counter cnt; 32-bit pend_hi and pend_lo.
- IDLE, e_op=mult/multu at edge E0: compute 64-bit product (signed for mult, unsigned for multu) into {pend_hi,pend_lo}, cnt<=MULT_CYC, busy<=1.
- IDLE, e_op=div/divu at edge E0: pend_lo<=quotient, pend_hi<=remainder (signed: truncation toward zero, remainder takes dividend's sign; unsigned for divu). cnt<=DIV_CYC, busy<=1.
- Divide by zero (e_rt==0): still starts and is busy for DIV_CYC cycles; on completion hi/lo stay unchanged.
- RUN: cnt decrements each edge. On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, busy<=0, cnt<=0. busy is therefore high for exactly N cycles after E0, and the new hi/lo are visible in the cycle after the Nth edge.
- mthi/mtlo in IDLE: hi<=e_rs (or lo<=e_rs) at that edge; busy stays 0.
- Any e_op (1..6) arriving in RUN is ignored; state is unaffected. The pipeline guarantees this cannot occur through stall_md; verification asserts the ignore.
- Completion edge with e_op in 1..4 on the same edge: not a start, because busy is still 1 at that edge. The new op starts only in a following IDLE cycle.
- stall_md is asserted during the start cycle as well as during RUN, so a D-stage mfhi/mflo never sees stale HI/LO.
- hi/lo are direct register outputs with no bypass of pend_*.
- e_op=0 or 7: no state change.

Test Plan:
- mult with e_rs=FFFFFFFF, e_rt=00000002 -> busy high for 5 cycles; then hi=FFFFFFFF, lo=FFFFFFFE. hi/lo hold their old values during busy.
- multu with the same operands -> hi=00000001, lo=FFFFFFFE after 5 cycles.
- div with e_rs=FFFFFFF9 (-7), e_rt=00000002 -> busy for 10 cycles; then lo=FFFFFFFD, hi=FFFFFFFF. divu 7/2 -> lo=3, hi=1.
- divu 7/0 with hi=AAAA0000, lo=0000BBBB preloaded via mthi/mtlo -> busy 10 cycles; hi/lo unchanged afterwards.
- Start mult, then drive div on cycle 2 with d_is_md=1 -> stall_md=1 in cycles 0..5, div ignored, hi/lo hold the mult result; stall_md=0 once busy drops and d_is_md=0.
- Start div, assert reset at cycle 4 -> busy=0, hi=0, lo=0 at the next edge; no late write afterwards.
